// File: rtl/plic_irq_gateway.sv
// plic_irq_gateway: platform interrupt gateway and claim arbiter.
// Each source is either a level source or a counted rising-edge source.
// Lowest eligible ID wins a claim. Line 0 is reserved and never pends.
// Optional IRQ_SYNC_EN: adds a 2-flop synchroniser on every irq_src_i bit.
module plic_irq_gateway #(
  parameter int unsigned NUM_SOURCES    = 32,
  parameter int unsigned ID_WIDTH       = $clog2(NUM_SOURCES),
  parameter int unsigned EDGE_CNT_WIDTH = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic [NUM_SOURCES-1:0] edge_mode_i,
  input  logic [NUM_SOURCES-1:0] enable_i,
  input  logic                   claim_req_i,
  output logic                   claim_valid_o,
  output logic [ID_WIDTH-1:0]    claim_id_o,
  input  logic                   complete_valid_i,
  input  logic [ID_WIDTH-1:0]    complete_id_i,
  output logic [NUM_SOURCES-1:0] pending_o,
  output logic                   irq_o
);

  logic [NUM_SOURCES-1:0]    src;
  logic [NUM_SOURCES-1:0]    src_q;
  logic [NUM_SOURCES-1:0]    rise;
  logic [NUM_SOURCES-1:0]    level_pend;
  logic [NUM_SOURCES-1:0]    in_service;
  logic [NUM_SOURCES-1:0]    pending;
  logic [NUM_SOURCES-1:0]    eligible;
  logic [NUM_SOURCES-1:0]    claim_hit;
  logic [NUM_SOURCES-1:0]    complete_hit;
  logic [EDGE_CNT_WIDTH-1:0] edge_cnt [NUM_SOURCES];
  logic [ID_WIDTH-1:0]       sel_id;
  logic                      sel_found;
  logic                      unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NUM_SOURCES-1:0] sync_q1;
  logic [NUM_SOURCES-1:0] sync_q2;

  // Two-flop synchroniser for asynchronous interrupt lines
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src = sync_q2;
`else
  assign src = irq_src_i;
`endif

  assign rise     = src & ~src_q;
  assign eligible = pending & enable_i;

  // Line 0 is reserved, so its bookkeeping bits are intentionally never read
  assign unused_bits = ^{edge_mode_i[0], rise[0], in_service[0], level_pend[0],
                         claim_hit[0], complete_hit[0], edge_cnt[0]};

  // Pending view: edge sources pend while their count is non-zero and idle
  always_comb begin
    pending = '0;
    for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
      if (edge_mode_i[i]) begin
        pending[i] = (edge_cnt[i] != '0) && !in_service[i];
      end else begin
        pending[i] = level_pend[i];
      end
    end
  end

  assign pending_o = pending;

  // Lowest-ID eligible source wins; completion decode is matched per source
  always_comb begin
    sel_id       = '0;
    sel_found    = 1'b0;
    claim_hit    = '0;
    complete_hit = '0;
    for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_found    = 1'b1;
        sel_id       = ID_WIDTH'(i);
        claim_hit[i] = claim_req_i;
      end
      complete_hit[i] = complete_valid_i && in_service[i] &&
                        (complete_id_i == ID_WIDTH'(i));
    end
  end

  // Per-source gateway state: edge history, level latch, in-service, edge count
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      src_q      <= '0;
      level_pend <= '0;
      in_service <= '0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        edge_cnt[i] <= '0;
      end
    end else begin
      src_q <= src;
      for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
        // claim and complete can never target the same source in one cycle
        if (claim_hit[i]) begin
          in_service[i] <= 1'b1;
        end else if (complete_hit[i]) begin
          in_service[i] <= 1'b0;
        end

        if (claim_hit[i]) begin
          level_pend[i] <= 1'b0;
        end else if (!edge_mode_i[i] && src[i] && !in_service[i]) begin
          level_pend[i] <= 1'b1;
        end

        if (edge_mode_i[i]) begin
          // a simultaneous edge and claim cancel out
          if (claim_hit[i] && !rise[i]) begin
            edge_cnt[i] <= edge_cnt[i] - EDGE_CNT_WIDTH'(1);
          end else if (rise[i] && !claim_hit[i] && (edge_cnt[i] != '1)) begin
            edge_cnt[i] <= edge_cnt[i] + EDGE_CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Registered core interrupt and claim response
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_o         <= 1'b0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      irq_o         <= |eligible;
      claim_valid_o <= claim_req_i;
      if (claim_req_i) begin
        claim_id_o <= sel_id;
      end
    end
  end

endmodule

// File: doc/plic_irq_gateway.md
Name: plic_irq_gateway

Overview:
- Parametrised platform-interrupt gateway and claim arbiter between peripheral interrupt lines (PBUS GPIO-in, timers, UART, future HBUS sources) and the PLIC-to-hart external interrupt.
- Generalises the fixed 32-line static map: source count, per-source edge/level mode, edge-count depth and per-source enables are all configurable.
- Provides pending tracking, lowest-ID-wins arbitration and a claim/complete handshake.
- Line 0 stays reserved.

Parameters:
- NUM_SOURCES, 32, number of interrupt lines including reserved line 0; range 2..64.
- ID_WIDTH, $clog2(NUM_SOURCES), width of claim/complete IDs.
- EDGE_CNT_WIDTH, 2, width of the per-source edge counter; saturates at 2**EDGE_CNT_WIDTH-1.

Ports:
- clock_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- irq_src_i  in  NUM_SOURCES  raw interrupt lines; bit 0 ignored
- edge_mode_i  in  NUM_SOURCES  quasi-static config: 1 = rising-edge source, 0 = level source
- enable_i  in  NUM_SOURCES  per-source enable
- claim_req_i  in  1  claim request pulse from hart/CSR path
- claim_valid_o  out  1  one-cycle strobe qualifying claim_id_o
- claim_id_o  out  ID_WIDTH  claimed source ID; 0 = nothing pending
- complete_valid_i  in  1  completion strobe
- complete_id_i  in  ID_WIDTH  ID being completed
- pending_o  out  NUM_SOURCES  current pending vector, for debug/CSR readback
- irq_o  out  1  registered external-interrupt request to core (CORE_EXT_INTERRUPT line)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: all pending, in-service, edge counters and edge-history flops = 0; irq_o = 0, claim_valid_o = 0, claim_id_o = 0, pending_o = 0.
- Source 0 is never pending, never claimed; completing ID 0 is ignored.
- Level source i:
  - Pending set on the cycle after irq_src_i[i]=1 while not pending and not in-service.
  - Cleared when claimed.
  - Re-armed only after completion.
  - Input deasserting before claim does not clear pending.
- Edge source i:
  - Rising edge is irq_src_i[i]=1 with previous sample 0. Each edge increments cnt[i], saturating at max; excess edges are dropped.
  - pending[i] = (cnt[i] != 0) & ~in_service[i].
  - Claim decrements cnt[i].
  - Edge and claim in the same cycle on the same source: counter unchanged.
- Edges are counted while in-service or while disabled.
- Eligible = pending & enable_i.
- irq_o registered: irq_o <= |eligible. Latency from source assertion to irq_o is 2 cycles.
- Claim, for claim_req_i sampled high in cycle N:
  - In cycle N+1, claim_valid_o=1 and claim_id_o = lowest eligible index in cycle N, else 0.
  - The selected source sets in_service and leaves pending in the same update.
  - Back-to-back requests each return distinct IDs.
  - claim_id_o holds its value after the strobe until the next claim.
- Complete:
  - complete_valid_i with an ID that is in service clears in_service the next cycle.
  - Out-of-range, zero or not-in-service IDs are ignored silently.
  - Complete and claim in the same cycle are independent: a source completed in cycle N is not claimable until cycle N+1 evaluation.
- Disabled source: pending retained, not eligible, not claimable; re-enabling makes it eligible immediately.
- edge_mode_i change: undefined for a source that is pending or in service; software changes it only while that source is disabled and idle.
- Reset mid-operation: everything clears immediately and asynchronously. Outstanding claims are lost, and no claim_valid_o strobe occurs after reset.

Optional Feature:
- IRQ_SYNC_EN defined: each irq_src_i bit passes through a 2-flop synchroniser before gateway logic. Source-to-irq_o latency becomes 4 cycles; edges shorter than one clock may be missed.
- Not defined: irq_src_i is used directly, for synchronous sources only; latency is 2 cycles.

Test Plan:
- Reset, then level source 4 held high:
  - irq_o=1 exactly 2 cycles later.
  - claim_req_i → claim_id_o=4, claim_valid_o one cycle.
  - irq_o drops; pending_o[4] stays 0 until complete_id_i=4, then re-asserts because the line is still high.
- Edge source 2, three pulses with EDGE_CNT_WIDTH=2:
  - Three successive claim+complete cycles each return ID 2.
  - A fourth claim returns 0.
- Edge source 2, five pulses while in service: saturates at 3, so three subsequent claims return 2.
- Sources 3 and 1 pending, 1 disabled:
  - Claim returns 3.
  - Enable 1, claim again: returns 1.
- claim_req_i with nothing pending → claim_valid_o=1, claim_id_o=0. complete_id_i=0 or 31-not-in-service → no state change.
- Reset asserted the cycle after a claim request → claim_valid_o stays 0, all outputs 0. With IRQ_SYNC_EN, level source 4 gives irq_o 4 cycles after assertion.
